// File: rtl/shared_dcache_pkg.sv
// Shared definitions for the data-cache arbiter: memory opcodes, FSM states
// and the memory-instruction decode helper.
package shared_dcache_pkg;

  localparam int          OP_W = 11;
  localparam logic [10:0] LDUR = 11'b11111000010;
  localparam logic [10:0] STUR = 11'b11111000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  function automatic logic is_mem_op(input logic [OP_W-1:0] opcode);
    return (opcode == LDUR) || (opcode == STUR);
  endfunction

endpackage

// File: rtl/shared_dcache_arbiter_rr_picker.sv
// Combinational round-robin find-first: first set bit of req scanning upward
// from ptr with wrap-around.
module rr_picker #(
  parameter int NUM_PORTS = 2,
  parameter int GRANT_W   = 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [GRANT_W-1:0]   ptr,
  output logic                 valid,
  output logic [GRANT_W-1:0]   idx
);

  logic [2*NUM_PORTS-1:0] rotated;
  int                     sum;

  // Rotating a doubled copy puts port ptr at bit 0, so the scan uses constant indices.
  always_comb begin
    rotated = {req, req} >> ptr;
    valid   = 1'b0;
    idx     = '0;
    sum     = 0;
    for (int off = NUM_PORTS - 1; off >= 0; off--) begin
      if (rotated[off]) begin
        sum = int'(ptr) + off;
        if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
        valid = 1'b1;
        idx   = GRANT_W'(sum);
      end
    end
  end

endmodule

// File: rtl/shared_dcache_arbiter.sv
// N-port round-robin arbiter between processor MEM stages and a multi-cycle data cache.
// Optional saturating performance counters are enabled with SHARED_DCACHE_ARB_PERF_CNT_EN.
module shared_dcache_arbiter
  import shared_dcache_pkg::*;
#(
  parameter  int NUM_PORTS = 2,
  parameter  int ADDR_W    = 64,
  parameter  int DATA_W    = 64,
  parameter  int OPCODE_W  = 11,
  localparam int GRANT_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS*OPCODE_W-1:0] port_opcode,
  input  logic [NUM_PORTS*ADDR_W-1:0]   port_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   port_wdata,
  output logic [NUM_PORTS-1:0]          port_enable,
  output logic [NUM_PORTS*DATA_W-1:0]   port_rdata,
  output logic                          cache_valid,
  output logic [OPCODE_W-1:0]           cache_opcode,
  output logic [ADDR_W-1:0]             cache_addr,
  output logic [DATA_W-1:0]             cache_wdata,
  input  logic [DATA_W-1:0]             cache_rdata,
  input  logic                          cache_ready,
  output logic [GRANT_W-1:0]            grant_id,
  output logic                          busy
`ifdef SHARED_DCACHE_ARB_PERF_CNT_EN
  ,
  output logic [NUM_PORTS*32-1:0]       perf_grants,
  output logic [NUM_PORTS*32-1:0]       perf_stall_cycles
`endif
);

  arb_state_t           state;
  logic [GRANT_W-1:0]   rr_ptr;
  logic [NUM_PORTS-1:0] mem_req;
  logic                 pick_valid;
  logic [GRANT_W-1:0]   pick_idx;
  logic [OPCODE_W-1:0]  sel_opcode;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic [DATA_W-1:0]    rdata_q [NUM_PORTS];

  always_comb begin
    mem_req = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      mem_req[i] = is_mem_op(port_opcode[i*OPCODE_W +: OPCODE_W]);
  end

  rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .GRANT_W   (GRANT_W)
  ) u_picker (
    .req   (mem_req),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    sel_opcode = '0;
    sel_addr   = '0;
    sel_wdata  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pick_idx == GRANT_W'(i)) begin
        sel_opcode = port_opcode[i*OPCODE_W +: OPCODE_W];
        sel_addr   = port_addr[i*ADDR_W +: ADDR_W];
        sel_wdata  = port_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      grant_id     <= '0;
      cache_valid  <= 1'b0;
      cache_opcode <= '0;
      cache_addr   <= '0;
      cache_wdata  <= '0;
      for (int i = 0; i < NUM_PORTS; i++) rdata_q[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_id     <= pick_idx;
            cache_opcode <= sel_opcode;
            cache_addr   <= sel_addr;
            cache_wdata  <= sel_wdata;
            cache_valid  <= 1'b1;
            state        <= BUSY;
          end
        end
        BUSY: begin
          if (cache_ready) begin
            if (cache_opcode == LDUR) begin
              for (int i = 0; i < NUM_PORTS; i++)
                if (grant_id == GRANT_W'(i)) rdata_q[i] <= cache_rdata;
            end
            rr_ptr      <= (grant_id == GRANT_W'(NUM_PORTS - 1)) ? '0 : grant_id + 1'b1;
            cache_valid <= 1'b0;
            state       <= DONE;
          end
        end
        // One idle cycle lets the granted core advance past its opcode before re-arbitration.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    port_enable = '0;
    if (!reset) begin
      for (int i = 0; i < NUM_PORTS; i++)
        port_enable[i] = ~mem_req[i] | ((state == DONE) && (grant_id == GRANT_W'(i)));
    end
  end

  assign busy = (state != IDLE);

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_rdata
    assign port_rdata[g*DATA_W +: DATA_W] = rdata_q[g];
  end

`ifdef SHARED_DCACHE_ARB_PERF_CNT_EN
  logic [31:0] grants_q [NUM_PORTS];
  logic [31:0] stalls_q [NUM_PORTS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        grants_q[i] <= '0;
        stalls_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if ((state == IDLE) && pick_valid && (pick_idx == GRANT_W'(i)) && (grants_q[i] != 32'hFFFF_FFFF))
          grants_q[i] <= grants_q[i] + 32'd1;
        if (!port_enable[i] && (stalls_q[i] != 32'hFFFF_FFFF))
          stalls_q[i] <= stalls_q[i] + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_perf
    assign perf_grants[g*32 +: 32]       = grants_q[g];
    assign perf_stall_cycles[g*32 +: 32] = stalls_q[g];
  end
`endif

endmodule

// File: doc/shared_dcache_arbiter.md
Name: shared_dcache_arbiter

Overview:
- N-port arbiter between ARMS2 processor cores and the shared data cache.
- Successor to the two-port combinational arbiter plus arbiterMux pair.
- Adds a registered round-robin grant, a valid/ready handshake to a multi-cycle cache, and per-port load-return registers.
- Stalls a core (enable low) while its LDUR/STUR is pending or in service; non-memory instructions never stall.

Parameters:
NUM_PORTS, 2, number of processor ports (>=1)
ADDR_W, 64, data address width
DATA_W, 64, data width
OPCODE_W, 11, opcode3 width from the processor MEM stage
GRANT_W, $clog2(NUM_PORTS) with minimum 1, grant index width (derived localparam)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
port_opcode  in  NUM_PORTS*OPCODE_W  per-port opcode3; slice i = port i
port_addr  in  NUM_PORTS*ADDR_W  per-port data address
port_wdata  in  NUM_PORTS*DATA_W  per-port store data
port_enable  out  NUM_PORTS  per-port processor/PC enable (1 = advance)
port_rdata  out  NUM_PORTS*DATA_W  per-port last load data returned
cache_valid  out  1  request to cache is valid
cache_opcode  out  OPCODE_W  opcode3 of the granted request
cache_addr  out  ADDR_W  address of the granted request
cache_wdata  out  DATA_W  store data of the granted request
cache_rdata  in  DATA_W  cache load data, sampled when cache_ready=1
cache_ready  in  1  cache completes the current request this cycle
grant_id  out  GRANT_W  index of the port currently in service
busy  out  1  state != IDLE

Behaviour:
- mem_req[i] = port_opcode slice i equals LDUR (11'b11111000010) or STUR (11'b11111000000).
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If any mem_req, pick the first requesting port scanning from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ... NUM_PORTS-1, 0, ...).
  - Register that port's opcode/addr/wdata onto cache_*, set grant_id, cache_valid<=1, go BUSY.
  - If no mem_req, stay IDLE; cache_valid=0.
- BUSY:
  - cache_* held stable.
  - When cache_ready=1: if the opcode is LDUR, port_rdata[grant_id] <= cache_rdata. Then cache_valid<=0, rr_ptr <= (grant_id+1) mod NUM_PORTS, go DONE.
  - cache_ready=0: remain BUSY, with no timeout.
- DONE: lasts exactly one cycle, with no arbitration that cycle, so the stale opcode of the granted port cannot re-issue. Then go IDLE.
- port_enable[i] = ~mem_req[i] | (state==DONE && grant_id==i). Combinational from registered state and inputs; forced 0 while reset=1.
- Latency:
  - A request visible before edge N gives cache_valid=1 after edge N.
  - With cache_ready asserted in cycle k, the enable pulse falls in cycle k+1.
  - Minimum 3 cycles per access; back-to-back grants every 3 cycles when cache_ready is tied high.
- port_rdata slices are held until the next load for that port. Stores never modify them.
- cache_ready while IDLE or DONE: ignored.
- A request withdrawn while waiting (opcode changes) simply drops out of arbitration. Once granted, a request completes regardless of input changes.
- Fairness: with all ports requesting continuously, each port is served once every NUM_PORTS grants.
- Reset (including mid-BUSY):
  - state IDLE, rr_ptr 0, grant_id 0, cache_valid 0.
  - cache_opcode/addr/wdata 0, all port_rdata 0, busy 0.
  - An in-flight request is abandoned.
- NUM_PORTS=1: grant_id fixed 0; same FSM.

Optional Feature:
- Macro: SHARED_DCACHE_ARB_PERF_CNT_EN.
- Defined: adds output ports perf_grants (NUM_PORTS*32) and perf_stall_cycles (NUM_PORTS*32).
  - perf_grants[i] increments on each IDLE->BUSY grant to i.
  - perf_stall_cycles[i] increments every cycle port_enable[i]=0 outside reset.
  - Both saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package shared_dcache_pkg holds:
  - LDUR/STUR opcode constants
  - FSM state enum (arb_state_t)
  - a function is_mem_op(opcode)
- Sub-module rr_picker: combinational round-robin find-first from rr_ptr over the req vector, returning a valid flag and an index.

Test Plan:
- Single load: port0 LDUR addr 0x500, cache_ready high 2 cycles after cache_valid, cache_rdata 0xDEAD -> cache_addr=0x500; port_rdata[0]=0xDEAD; port_enable[0] low through BUSY and high exactly one cycle in DONE.
- Contention, NUM_PORTS=4: all ports STUR simultaneously, cache_ready tied 1 -> grant order 0,1,2,3,0 at 3-cycle spacing; port_rdata unchanged.
- Non-memory bypass: port1 ADD while port0 is in BUSY -> port_enable[1]=1 every cycle; grant_id stays 0.
- Stalled cache: cache_ready held 0 for 20 cycles -> cache_* stable, busy=1, all requesting ports disabled; completes on the first ready.
- Reset mid-BUSY: assert reset in cycle 2 of BUSY -> next cycle cache_valid=0, rr_ptr=0, port_rdata=0; a later request from port2 is granted cleanly.
- Perf counters (macro defined): port1 waits 5 cycles and is then granted -> perf_stall_cycles[1]=6 (including the BUSY cycles); perf_grants[1]=1.
